// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-ported register file with hardwired zero register and per-register busy scoreboard
// Optional REGFILE_BYPASS_EN forwards the writeback value and busy-clear to the read ports in the same cycle.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [ADDR_W:0]   r_pend_cnt;

  logic [DEPTH-1:0]  w_busy_nxt;
  logic [ADDR_W:0]   w_pend_nxt;
  logic [DATA_W-1:0] w_rd_data1;
  logic [DATA_W-1:0] w_rd_data2;
  logic              w_rd_busy1;
  logic              w_rd_busy2;

  // Issue is applied after writeback so a new producer supersedes the one retiring.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wr_en) begin
      w_busy_nxt[wr_addr] = 1'b0;
    end
    if (iss_en && (iss_addr != '0)) begin
      w_busy_nxt[iss_addr] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_comb begin
    w_pend_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_pend_nxt = w_pend_nxt + (ADDR_W+1)'(w_busy_nxt[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      r_busy     <= '0;
      r_pend_cnt <= '0;
    end else begin
      if (wr_en && (wr_addr != '0)) begin
        r_regs[wr_addr] <= wr_data;
      end
      r_busy     <= w_busy_nxt;
      r_pend_cnt <= w_pend_nxt;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic w_wr_hit1;
  logic w_wr_hit2;
  logic w_iss_hit1;
  logic w_iss_hit2;

  assign w_wr_hit1  = wr_en && (wr_addr == rd_addr1) && (rd_addr1 != '0);
  assign w_wr_hit2  = wr_en && (wr_addr == rd_addr2) && (rd_addr2 != '0);
  assign w_iss_hit1 = iss_en && (iss_addr == rd_addr1);
  assign w_iss_hit2 = iss_en && (iss_addr == rd_addr2);

  assign w_rd_data1 = w_wr_hit1 ? wr_data : r_regs[rd_addr1];
  assign w_rd_data2 = w_wr_hit2 ? wr_data : r_regs[rd_addr2];
  assign w_rd_busy1 = r_busy[rd_addr1] && !(w_wr_hit1 && !w_iss_hit1);
  assign w_rd_busy2 = r_busy[rd_addr2] && !(w_wr_hit2 && !w_iss_hit2);
`else
  assign w_rd_data1 = r_regs[rd_addr1];
  assign w_rd_data2 = r_regs[rd_addr2];
  assign w_rd_busy1 = r_busy[rd_addr1];
  assign w_rd_busy2 = r_busy[rd_addr2];
`endif

  // Outputs are forced quiet while reset is held, which also masks any forwarded wr_data.
  assign rd_data1 = reset ? '0 : w_rd_data1;
  assign rd_data2 = reset ? '0 : w_rd_data2;
  assign rd_busy1 = reset ? 1'b0 : w_rd_busy1;
  assign rd_busy2 = reset ? 1'b0 : w_rd_busy2;
  assign pend_cnt = r_pend_cnt;

endmodule
